// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and constants for the 4-bit multiply-accumulate
//               block: FSM state enum, operand/product widths and the width
//               of the term counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Accumulate vs. hold-result state of the MAC controller.
    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } mac_state_t;

    localparam int c_OPERAND_W = 4;
    localparam int c_PRODUCT_W = 8;
    // Wide enough to count up to 16 terms (values 0..15 are ever stored).
    localparam int c_CNT_W     = 5;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_accumulator_4bit_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulator_4bit_if
// Description : Bus bundle for mac_accumulator_4bit.
//               Producer side : clr, a, b, in_valid  -> in_ready
//               Consumer side : sum, ovf, out_valid  <- out_ready
//               master modport = environment driving the MAC,
//               slave modport  = the MAC itself.
// Parameters  : ACC_W - width of the sum bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_accumulator_4bit_if
    import mac_pkg::*;
#(
    parameter int ACC_W = 10
) ();

    logic                   clr;
    logic [c_OPERAND_W-1:0] a;
    logic [c_OPERAND_W-1:0] b;
    logic                   in_valid;
    logic                   in_ready;
    logic [ACC_W-1:0]       sum;
    logic                   ovf;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output clr, a, b, in_valid, out_ready,
        input  in_ready, sum, ovf, out_valid
    );

    modport slave (
        input  clr, a, b, in_valid, out_ready,
        output in_ready, sum, ovf, out_valid
    );

endinterface : mac_accumulator_4bit_if
`default_nettype wire

// File: rtl/array_multiplier_4bit.sv
`default_nettype none
// ============================================================================
// Module      : array_multiplier_4bit
// Description : Combinational 4x4 unsigned array multiplier. Each bit of b
//               gates a shifted copy of a; the rows are summed in a ripple
//               chain.
// Ports       : a [3:0] in  - multiplicand
//               b [3:0] in  - multiplier
//               z [7:0] out - unsigned product a*b
// Revision    : 1.0 - initial release
// ============================================================================
module array_multiplier_4bit (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    output logic      [7:0] z
);

    logic [7:0] w_pp  [4];
    logic [7:0] w_row [5];

    assign w_row[0] = 8'd0;

    for (genvar i = 0; i < 4; i++) begin : g_row
        assign w_pp[i]    = {4'd0, (a & {4{b[i]}})} << i;
        assign w_row[i+1] = w_row[i] + w_pp[i];
    end

    assign z = w_row[4];

endmodule : array_multiplier_4bit
`default_nettype wire

// File: rtl/mac_accumulator_4bit.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulator_4bit
// Description : Sums N_TERMS unsigned 4x4 products and presents the result
//               with a valid/ready handshake. While a result is held the
//               input side is stalled (in_ready=0).
// Ports       : clk   in  - clock, rising edge
//               rst_n in  - asynchronous active-low reset
//               bus   slave modport of mac_accumulator_4bit_if:
//                     clr, a, b, in_valid (in) / in_ready (out)
//                     sum, ovf, out_valid (out) / out_ready (in)
// Parameters  : N_TERMS 1..16 - products per result
//               ACC_W   8..16 - accumulator / sum width
// Build macro : MAC_SATURATE_EN - when defined the accumulator clamps to
//               all-ones on overflow; otherwise it wraps. ovf is set in
//               both cases.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulator_4bit
    import mac_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 10
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    mac_accumulator_4bit_if.slave bus
);

    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(N_TERMS - 1);

    mac_state_t             r_state;
    mac_state_t             w_state_nxt;
    logic [ACC_W-1:0]       r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_ovf_trk;
    logic [ACC_W-1:0]       r_sum;
    logic                   r_ovf;

    logic [c_PRODUCT_W-1:0] w_prod;
    logic [ACC_W:0]         w_add;
    logic                   w_carry;
    logic [ACC_W-1:0]       w_acc_nxt;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_in_ready;
    logic                   w_out_valid;

    // ------------------------------------------------------------------
    // Product
    // ------------------------------------------------------------------
    array_multiplier_4bit u_mult (
        .a (bus.a),
        .b (bus.b),
        .z (w_prod)
    );

    // ------------------------------------------------------------------
    // Accumulate path: one extra bit catches the carry out of ACC_W.
    // ------------------------------------------------------------------
    assign w_add   = {1'b0, r_acc} + {{(ACC_W + 1 - c_PRODUCT_W){1'b0}}, w_prod};
    assign w_carry = w_add[ACC_W];

    always_comb begin
        w_acc_nxt = w_add[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
        // Once clamped, any further non-zero product carries again, so the
        // accumulator stays pinned at all-ones for the rest of the sum.
        if (w_carry) begin
            w_acc_nxt = {ACC_W{1'b1}};
        end
`else
        // Wrap modulo 2^ACC_W: the carry is simply dropped.
        w_acc_nxt = w_add[ACC_W-1:0];
`endif
    end

    assign w_accept = (r_state == ACC) && bus.in_valid && !bus.clr;
    assign w_last   = (r_cnt == c_LAST_CNT);

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and handshake outputs. Handshake outputs
    // depend on the registered state only, so out_ready never reaches
    // in_ready combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ACC: begin
                w_in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ACC;
                end
            end
            default: begin
                w_state_nxt = ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Only touched in ACC, so clr is ignored and the result
    // registers stay frozen while a result is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_trk <= 1'b0;
            r_sum     <= '0;
            r_ovf     <= 1'b0;
        end else if (r_state == ACC) begin
            if (bus.clr) begin
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ovf_trk <= 1'b0;
            end else if (bus.in_valid) begin
                if (w_last) begin
                    r_sum     <= w_acc_nxt;
                    r_ovf     <= r_ovf_trk | w_carry;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf_trk <= 1'b0;
                end else begin
                    r_acc     <= w_acc_nxt;
                    r_cnt     <= r_cnt + 1'b1;
                    r_ovf_trk <= r_ovf_trk | w_carry;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.ovf       = r_ovf;

endmodule : mac_accumulator_4bit
`default_nettype wire

// File: tb/tb_mac_accumulator_4bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accumulator_4bit
// Description : Self-checking bench for mac_accumulator_4bit. The driver
//               keeps a reference model (running integer total, term count,
//               hold flag) and pushes each expected result into a queue; an
//               independent monitor compares sum/ovf whenever out_valid is
//               high and pops on the handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator_4bit;
    import mac_pkg::*;

    localparam int N_TERMS = 8;
    localparam int ACC_W   = 10;
    localparam int c_LIM   = 1 << ACC_W;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mac_accumulator_4bit_if #(.ACC_W(ACC_W)) bus ();

    mac_accumulator_4bit #(
        .N_TERMS (N_TERMS),
        .ACC_W   (ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_total = 0;
    int   m_cnt   = 0;
    bit   m_hold  = 1'b0;

    // Result of a completed sum from the true (unbounded) total.
    function automatic res_t model_result(input int total);
        res_t r;
        r.ovf = (total >= c_LIM);
`ifdef MAC_SATURATE_EN
        r.sum = r.ovf ? ACC_W'(c_LIM - 1) : ACC_W'(total);
`else
        r.sum = ACC_W'(total % c_LIM);
`endif
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock cycle: apply inputs, update the model at the edge, then
    // check in_ready against the model's view of whether a result is held.
    task automatic cyc(input bit v, input logic [3:0] aa, input logic [3:0] bb,
                       input bit c, input bit ordy);
        bus.in_valid  = v;
        bus.a         = aa;
        bus.b         = bb;
        bus.clr       = c;
        bus.out_ready = ordy;
        @(posedge clk);
        if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (c) begin
            m_total = 0;
            m_cnt   = 0;
        end else if (v) begin
            m_total += int'(aa) * int'(bb);
            m_cnt++;
            if (m_cnt == N_TERMS) begin
                exp_q.push_back(model_result(m_total));
                m_total = 0;
                m_cnt   = 0;
                m_hold  = 1'b1;
            end
        end
        #1;
        check("in_ready", int'(bus.in_ready), int'(!m_hold));
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_sum",       int'(bus.sum),       0);
        check("rst_ovf",       int'(bus.ovf),       0);
        m_total = 0;
        m_cnt   = 0;
        m_hold  = 1'b0;
        exp_q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare the held result every cycle it is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got sum %0d with no result expected", bus.sum);
                end else begin
                    check("sum", int'(bus.sum), int'(exp_q[0].sum));
                    check("ovf", int'(bus.ovf), int'(exp_q[0].ovf));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int held_sum;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.clr       = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        pulse_reset();

        // Squares 0..7 sum to 140.
        for (int j = 0; j < 8; j++) cyc(1'b1, 4'(j), 4'(j), 1'b0, 1'b0);
        check("sq_out_valid", int'(bus.out_valid), 1);
        check("sq_sum", int'(bus.sum), 140);
        check("sq_ovf", int'(bus.ovf), 0);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Eight 15*15 = 1800 overflows a 10-bit accumulator.
        for (int j = 0; j < 8; j++) cyc(1'b1, 4'd15, 4'd15, 1'b0, 1'b0);
`ifdef MAC_SATURATE_EN
        check("big_sum", int'(bus.sum), 1023);
`else
        check("big_sum", int'(bus.sum), 776);
`endif
        check("big_ovf", int'(bus.ovf), 1);
        held_sum = int'(bus.sum);

        // Back-pressure: offered pairs and clr must not disturb the result.
        for (int j = 0; j < 5; j++)
            cyc(1'b1, 4'($urandom), 4'($urandom), (j == 2), 1'b0);
        check("hold_sum", int'(bus.sum), held_sum);
        check("hold_out_valid", int'(bus.out_valid), 1);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Abort partial sum; the pair offered with clr is discarded.
        for (int j = 0; j < 3; j++) cyc(1'b1, 4'd2, 4'd3, 1'b0, 1'b1);
        cyc(1'b1, 4'd15, 4'd15, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++) cyc(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
        check("clr_sum", int'(bus.sum), 8);
        check("clr_ovf", int'(bus.ovf), 0);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Reset mid-sum, then a full random sum.
        for (int j = 0; j < 4; j++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        pulse_reset();
        for (int j = 0; j < 8; j++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Reset while a result is held.
        for (int j = 0; j < 8; j++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        pulse_reset();

        // in_valid toggling over 16 cycles.
        for (int j = 0; j < 16; j++)
            cyc((j % 2) == 0, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Randomised traffic.
        for (int j = 0; j < 400; j++)
            cyc($urandom_range(0, 9) < 7, 4'($urandom), 4'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);

        // Drain any held result.
        for (int j = 0; j < 3; j++) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mac_accumulator_4bit
`default_nettype wire

// File: doc/mac_accumulator_4bit.md
MAC_ACCUMULATOR_4BIT -- requirements
Module: mac_accumulator_4bit

Interface
REQ-001 SHALL have parameter N_TERMS, default 8: products summed per result, legal range 1..16.
REQ-002 SHALL have parameter ACC_W, default 10: accumulator and result width, legal range 8..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1: synchronous abort of the current sum.
REQ-006 SHALL have port a, input, 4: unsigned operand A.
REQ-007 SHALL have port b, input, 4: unsigned operand B.
REQ-008 SHALL have port in_valid, input, 1: a/b pair offered.
REQ-009 SHALL have port in_ready, output, 1: block accepts a pair this cycle.
REQ-010 SHALL have port sum, output, ACC_W: completed sum of products.
REQ-011 SHALL have port ovf, output, 1: overflow occurred during the completed sum.
REQ-012 SHALL have port out_valid, output, 1: sum/ovf valid.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result.

Function
REQ-014 SHALL be an FSM with two states, ACC and HOLD.
REQ-015 SHALL drive in_ready=1 and out_valid=0 in ACC, and in_ready=0 and out_valid=1 in HOLD.
REQ-016 SHALL accept a pair on a clk edge where state is ACC, in_valid=1 and clr=0.
REQ-017 SHALL, on each accept, form the 8-bit unsigned product a*b, zero-extend it to ACC_W+1 bits, add it to acc, and increment the 5-bit term counter cnt.
REQ-018 SHALL, when the accepted pair is term N_TERMS (cnt==N_TERMS-1), load sum and ovf with the final values, clear acc and cnt, and enter HOLD.
REQ-019 SHALL assert out_valid in the cycle after the last accept (latency 1).
REQ-020 SHALL hold sum and ovf stable while out_valid=1 and out_ready=0.
REQ-021 SHALL return to ACC on a clk edge in HOLD with out_ready=1; in_ready rises the following cycle, with no combinational path from out_ready to in_ready.
REQ-022 SHALL, on clr=1 in ACC, zero acc, cnt and the overflow tracker and discard any simultaneous input pair.
REQ-023 SHALL ignore clr in HOLD; the pending result is not lost.
REQ-024 SHALL set the internal overflow tracker when an addition carries beyond ACC_W bits, and report it on ovf for that sum only.
REQ-025 SHALL, with N_TERMS=1, enter HOLD on every accept.

Reset
REQ-026 SHALL, while rst_n=0, force state=ACC, acc=0, cnt=0, sum=0, ovf=0, out_valid=0 and in_ready=1, independent of clk.
REQ-027 SHALL, when reset is asserted mid-sum or in HOLD, discard all partial and pending results.

Configuration
REQ-028 SHALL, with MAC_SATURATE_EN defined, clamp acc to 2^ACC_W-1 on overflow, hold it there for the rest of the sum, and still set ovf.
REQ-029 SHALL, with MAC_SATURATE_EN undefined, wrap acc modulo 2^ACC_W on overflow and set ovf.

Structure
REQ-030 SHALL take from a shared package mac_pkg: the state enum (ACC, HOLD), the operand width constant (4) and the product width constant (8).
REQ-031 SHALL compute the product by instantiating the existing array_multiplier_4bit (ports a, b, z) as its only sub-module.

Verification
REQ-032 SHALL cover: reset, then 8 pairs a=j, b=j for j=0..7 at one per cycle -> out_valid one cycle after the 8th accept, sum=140, ovf=0.
REQ-033 SHALL cover: 8 pairs of a=15, b=15 with ACC_W=10 -> ovf=1; sum=1800 mod 1024=776 without MAC_SATURATE_EN, sum=1023 with it.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0 throughout, sum stable, no input accepted.
REQ-035 SHALL cover: 3 pairs (2*3 each), then clr=1 with in_valid=1 and a=15, b=15, then 8 pairs of 1*1 -> sum=8.
REQ-036 SHALL cover: rst_n pulsed low after 4 accepts -> all outputs 0 immediately; a following full 8-pair sum is correct.
REQ-037 SHALL cover: in_valid toggling 1,0,1,0 over 16 cycles with N_TERMS=8 -> only cycles with in_valid=1 are counted, sum matches a reference model.
